// File: rtl/alu_exec_stage_pkg.sv
// Shared constants for the execute stage: ALU op codes, ALUOp encodings, default width.
package alu_exec_stage_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // {ALUOp[1], ALUOp[0]} from main control
  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_RTYPE = 2'b10
  } aluop_e;

endpackage

// File: rtl/alu_exec_stage_op_decode.sv
// ALU control: maps ALUOp and the low funct bits to a 3-bit ALU operation code.
module alu_op_decode
  import alu_exec_stage_pkg::*;
(
  input  logic       i_aluop1,
  input  logic       i_aluop0,
  input  logic [3:0] i_funct,
  output logic [2:0] o_gout
);

  // Branch compare takes priority over the R-type field decode.
  always_comb begin
    o_gout = ALU_ADD;
    if (i_aluop0)                           o_gout = ALU_SUB;
    else if (i_aluop1) begin
      if      (!i_funct[3] && i_funct[1])   o_gout = ALU_SUB;
      else if ( i_funct[3] && i_funct[1])   o_gout = ALU_SLT;
      else if ( i_funct[2] && i_funct[0])   o_gout = ALU_OR;
      else if ( i_funct[2] && !i_funct[0])  o_gout = ALU_AND;
      else                                  o_gout = ALU_ADD;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: ALU control decode, ALU with flags, PC+4 and branch target.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int PC_INC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             aluop1,
  input  logic             aluop0,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] offset,
  output logic             valid_out,
  output logic [2:0]       gout,
  output logic [WIDTH-1:0] sum,
  output logic             zout,
  output logic             vout,
  output logic             grtz,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] br_target
);

  logic [2:0]       w_gout;
  logic [WIDTH-1:0] w_add, w_sub, w_res, w_pc4, w_br;
  logic             w_lt, w_v, w_z, w_gtz;

  alu_op_decode u_dec (
    .i_aluop1 (aluop1),
    .i_aluop0 (aluop0),
    .i_funct  (funct),
    .o_gout   (w_gout)
  );

  assign w_add = a + b;
  assign w_sub = a - b;
  // True signed compare, so slt stays correct when a-b overflows.
  assign w_lt  = $signed(a) < $signed(b);

  always_comb begin
    w_res = '0;
    w_v   = 1'b0;
    case (w_gout)
      ALU_AND: w_res = a & b;
      ALU_OR:  w_res = a | b;
      ALU_ADD: begin
        w_res = w_add;
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_res = w_sub;
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: w_res = {{(WIDTH-1){1'b0}}, w_lt};
      default: begin
        w_res = '0;
        w_v   = 1'b0;
      end
    endcase
  end

  assign w_z   = (w_res == '0);
  assign w_gtz = !w_res[WIDTH-1] && !w_z;
  assign w_pc4 = pc + WIDTH'(PC_INC);
  assign w_br  = w_pc4 + {offset[WIDTH-3:0], 2'b00};

  logic             r_valid;
  logic [2:0]       r_gout;
  logic [WIDTH-1:0] r_sum, r_pc4, r_br;
  logic             r_z, r_v, r_gtz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_gout  <= '0;
      r_sum   <= '0;
      r_z     <= 1'b0;
      r_v     <= 1'b0;
      r_gtz   <= 1'b0;
      r_pc4   <= '0;
      r_br    <= '0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_gout <= w_gout;
        r_sum  <= w_res;
        r_z    <= w_z;
        r_v    <= w_v;
        r_gtz  <= w_gtz;
        r_pc4  <= w_pc4;
        r_br   <= w_br;
      end
    end
  end

  assign valid_out = r_valid;
  assign gout      = r_gout;
  assign sum       = r_sum;
  assign zout      = r_z;
  assign vout      = r_v;
  assign grtz      = r_gtz;
  assign pc_plus4  = r_pc4;
  assign br_target = r_br;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed table-driven bench for alu_exec_stage plus reset/hold sequences.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        aluop1, aluop0;
  logic [3:0]  funct;
  logic [31:0] a, b, pc, offset;
  logic        valid_out;
  logic [2:0]  gout;
  logic [31:0] sum, pc_plus4, br_target;
  logic        zout, vout, grtz;

  int nchk = 0;
  int nerr = 0;

  alu_exec_stage #(.WIDTH(32), .PC_INC(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .aluop1(aluop1), .aluop0(aluop0), .funct(funct),
    .a(a), .b(b), .pc(pc), .offset(offset),
    .valid_out(valid_out), .gout(gout), .sum(sum),
    .zout(zout), .vout(vout), .grtz(grtz),
    .pc_plus4(pc_plus4), .br_target(br_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic [31:0] a, b, pc, offset;
    logic [2:0]  gout;
    logic [31:0] sum;
    logic        z, v, g;
    logic [31:0] pc4, br;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid_out"}, {31'd0, valid_out}, 32'd0);
    chk({tag, ".gout"},      {29'd0, gout},      32'd0);
    chk({tag, ".sum"},       sum,                32'd0);
    chk({tag, ".flags"},     {29'd0, zout, vout, grtz}, 32'd0);
    chk({tag, ".pc_plus4"},  pc_plus4,           32'd0);
    chk({tag, ".br_target"}, br_target,          32'd0);
  endtask

  task automatic drive(input vec_t v, input logic vin);
    valid_in = vin;
    {aluop1, aluop0} = v.aluop;
    funct  = v.funct;
    a      = v.a;
    b      = v.b;
    pc     = v.pc;
    offset = v.offset;
  endtask

  task automatic check_vec(input vec_t v);
    chk({v.name, ".valid_out"}, {31'd0, valid_out}, 32'd1);
    chk({v.name, ".gout"},      {29'd0, gout},      {29'd0, v.gout});
    chk({v.name, ".sum"},       sum,                v.sum);
    chk({v.name, ".zout"},      {31'd0, zout},      {31'd0, v.z});
    chk({v.name, ".vout"},      {31'd0, vout},      {31'd0, v.v});
    chk({v.name, ".grtz"},      {31'd0, grtz},      {31'd0, v.g});
    chk({v.name, ".pc_plus4"},  pc_plus4,           v.pc4);
    chk({v.name, ".br_target"}, br_target,          v.br);
  endtask

  initial begin
    //           name         op     funct  a             b             pc            offset        gout    sum           z     v     g     pc4           br
    vecs[0]  = '{"lw_add",    2'b00, 4'h0, 32'h10,       32'h4,        32'h8,        32'h2,        3'b010, 32'h14,       1'b0, 1'b0, 1'b1, 32'hC,        32'h14};
    vecs[1]  = '{"beq_eq",    2'b01, 4'h0, 32'h1234,     32'h1234,     32'h100,      32'h0,        3'b110, 32'h0,        1'b1, 1'b0, 1'b0, 32'h104,      32'h104};
    vecs[2]  = '{"sub_ovf",   2'b01, 4'h0, 32'h80000000, 32'h1,        32'h0,        32'h1,        3'b110, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 32'h4,        32'h8};
    vecs[3]  = '{"r_and",     2'b10, 4'h4, 32'hF,        32'hFFFFFFF0, 32'h20,       32'h10,       3'b000, 32'h0,        1'b1, 1'b0, 1'b0, 32'h24,       32'h64};
    vecs[4]  = '{"r_or",      2'b10, 4'h5, 32'hF,        32'hFFFFFFF0, 32'h1000,     32'hFFFFFFFF, 3'b001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h1004,     32'h1000};
    vecs[5]  = '{"slt_f_neg", 2'b10, 4'hA, 32'hF,        32'hFFFFFFF0, 32'h0,        32'h0,        3'b111, 32'h0,        1'b1, 1'b0, 1'b0, 32'h4,        32'h4};
    vecs[6]  = '{"slt_m1_1",  2'b10, 4'hA, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        3'b111, 32'h1,        1'b0, 1'b0, 1'b1, 32'h4,        32'h4};
    vecs[7]  = '{"r_sub_neg", 2'b10, 4'h2, 32'h5,        32'h7,        32'h0,        32'h0,        3'b110, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 32'h4,        32'h4};
    vecs[8]  = '{"add_ovf_pcwrap", 2'b10, 4'h0, 32'h7FFFFFFF, 32'h1,   32'hFFFFFFFC, 32'h0,        3'b010, 32'h80000000, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[9]  = '{"slt_ovf",   2'b10, 4'hA, 32'h80000000, 32'h1,        32'h0,        32'h0,        3'b111, 32'h1,        1'b0, 1'b0, 1'b1, 32'h4,        32'h4};
    vecs[10] = '{"aluop11",   2'b11, 4'h5, 32'h3,        32'h3,        32'h0,        32'h0,        3'b110, 32'h0,        1'b1, 1'b0, 1'b0, 32'h4,        32'h4};
    vecs[11] = '{"r_0110",    2'b10, 4'h6, 32'hA,        32'h3,        32'h0,        32'h0,        3'b110, 32'h7,        1'b0, 1'b0, 1'b1, 32'h4,        32'h4};
    vecs[12] = '{"r_1111",    2'b10, 4'hF, 32'h2,        32'h3,        32'h0,        32'h0,        3'b111, 32'h1,        1'b0, 1'b0, 1'b1, 32'h4,        32'h4};
    vecs[13] = '{"r_1000",    2'b10, 4'h8, 32'h1,        32'h2,        32'h0,        32'h0,        3'b010, 32'h3,        1'b0, 1'b0, 1'b1, 32'h4,        32'h4};
    vecs[14] = '{"r_1101",    2'b10, 4'hD, 32'hF0,       32'h0F,       32'h0,        32'h0,        3'b001, 32'hFF,       1'b0, 1'b0, 1'b1, 32'h4,        32'h4};
    vecs[15] = '{"sub_povf",  2'b01, 4'h0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        3'b110, 32'h80000000, 1'b0, 1'b1, 1'b0, 32'h4,        32'h4};
    vecs[16] = '{"add_novf",  2'b00, 4'h0, 32'h80000000, 32'h80000000, 32'h40,       32'h3FFFFFFF, 3'b010, 32'h0,        1'b1, 1'b1, 1'b0, 32'h44,       32'h40};

    // Reset with no clock edge yet.
    rst_n = 1'b0;
    drive(vecs[0], 1'b0);
    #2;
    chk_all_zero("reset_init");

    // Release with valid_in low: nothing captured.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all_zero("idle_after_reset");

    // Main table: one op per cycle, result one cycle later.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i], 1'b1);
      @(posedge clk); #1;
      check_vec(vecs[i]);
    end

    // Hold: different operands with valid_in low must not load.
    @(negedge clk);
    drive(vecs[0], 1'b0);
    @(posedge clk); #1;
    chk("hold.valid_out", {31'd0, valid_out}, 32'd0);
    chk("hold.sum",       sum,       vecs[NV-1].sum);
    chk("hold.zout",      {31'd0, zout}, {31'd0, vecs[NV-1].z});
    chk("hold.vout",      {31'd0, vout}, {31'd0, vecs[NV-1].v});
    chk("hold.pc_plus4",  pc_plus4,  vecs[NV-1].pc4);
    chk("hold.br_target", br_target, vecs[NV-1].br);

    // Back-to-back capture then asynchronous reset mid-cycle.
    @(negedge clk);
    drive(vecs[4], 1'b1);
    @(posedge clk); #1;
    check_vec(vecs[4]);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_midcycle");

    // First capture after release lands on the first valid edge.
    @(negedge clk);
    rst_n = 1'b1;
    drive(vecs[6], 1'b1);
    @(posedge clk); #1;
    check_vec(vecs[6]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Registered execute stage for the single-cycle MIPS-subset datapath.
- Decodes ALUOp plus funct into a 3-bit ALU operation code.
- Performs the 32-bit ALU operation and derives the zero, overflow and greater-than-zero flags.
- Computes PC+4 and the branch target (PC+4 + offset<<2).
- Registers all results so control and branch logic see stable values one cycle later.

Parameters:
WIDTH, 32, datapath width of operands, PC and results
PC_INC, 4, constant added to PC by the PC incrementer

Ports:
clk        in   1      rising-edge clock
rst_n      in   1      asynchronous active-low reset
valid_in   in   1      operands valid this cycle; capture enable
aluop1     in   1      ALUOp[1] from control (R-type)
aluop0     in   1      ALUOp[0] from control (branch compare)
funct      in   4      instruction bits [3:0]
a          in   WIDTH  operand A (register read data 1)
b          in   WIDTH  operand B (ALUSrc mux output)
pc         in   WIDTH  current program counter
offset     in   WIDTH  sign-extended immediate (unshifted)
valid_out  out  1      registered results valid
gout       out  3      registered ALU operation code
sum        out  WIDTH  registered ALU result
zout       out  1      registered zero flag
vout       out  1      registered signed-overflow flag
grtz       out  1      registered signed result > 0
pc_plus4   out  WIDTH  registered pc + PC_INC
br_target  out  WIDTH  registered pc + PC_INC + (offset << 2)

Behaviour:
ALU control decode (combinational), first match wins:
- aluop1=0, aluop0=0: gout=010 (add).
- aluop0=1, any aluop1: gout=110 (subtract).
- aluop1=1, aluop0=0 (R-type):
  - funct[3]=0 and funct[1]=1: 110 (sub).
  - funct[3]=1 and funct[1]=1: 111 (slt).
  - funct[2]=1 and funct[0]=1: 001 (or).
  - funct[2]=1 and funct[0]=0: 000 (and).
  - otherwise: 010 (add).

ALU operations (combinational):
- 000: a & b.
- 001: a | b.
- 010: a + b, modulo 2^WIDTH.
- 110: a - b, modulo 2^WIDTH.
- 111: 1 if signed a < signed b, else 0. Uses a true signed compare, correct even when a-b overflows.
- 011, 100, 101: result 0, vout 0.

Flags:
- zout = (result == 0).
- vout, add: operand signs equal and result sign differs.
- vout, sub: operand signs differ and result sign differs from a.
- vout = 0 for all other ops.
- grtz = (result[WIDTH-1] == 0) and (result != 0).

Adders:
- pc_plus4 = pc + PC_INC.
- br_target = pc_plus4 + (offset << 2). Both wrap modulo 2^WIDTH; no carry out.

Registering:
- Output registers load on the rising edge of clk when valid_in=1. They hold when valid_in=0.
- valid_out register loads valid_in every cycle.
- Latency is exactly 1 cycle; throughput is 1 operation per cycle.

Reset:
- rst_n=0 asynchronously clears every output register to 0 (gout=000, sum=0, flags=0, valid_out=0).
- Asserting reset mid-operation discards any captured result immediately.
- First capture after release happens on the first rising edge with rst_n=1 and valid_in=1.

Decomposition:
Shared package holds:
- ALU op constants: ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111.
- ALUOp encodings.
- WIDTH default.

Natural sub-module alu_op_decode: the combinational ALUOp/funct to gout map. The ALU core, adders and registers stay in the top.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with outputs nonzero → all outputs 0 immediately, before any clock edge.
- lw/sw add: aluop=00, a=0x10, b=0x4, pc=0x8, offset=0x2, valid_in=1 → next cycle gout=010, sum=0x14, zout=0, grtz=1, pc_plus4=0xC, br_target=0x14.
- beq compare: aluop=01, a=b=0x1234 → gout=110, sum=0, zout=1, grtz=0.
- Subtract overflow: aluop=01, a=0x80000000, b=1 → sum=0x7FFFFFFF, vout=1, grtz=1.
- R-type sweep with a=0x0000000F, b=0xFFFFFFF0:
  - funct 0100 → sum=0.
  - funct 0101 → sum=0xFFFFFFFF.
  - funct 1010 (slt) → sum=0; with a=-1, b=1 → sum=1.
- Hold and wrap:
  - valid_in=0 → outputs unchanged and valid_out=0.
  - pc=0xFFFFFFFC → pc_plus4=0.
  - offset=0xFFFFFFFF → br_target = pc_plus4 - 4.
